irig_b_decoder: RTL and testbench

IRIG_B_DECODER -- requirements
Module: irig_b_decoder

---
 rtl/irig_b_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_irig_b_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/irig_b_decoder.sv
// irig_b_decoder
//   Decodes an IRIG-B DC-level (pulse-width) time code into BCD
//   hours/minutes/seconds and regenerates an on-time pps pulse.
//
//   The block hunts for two consecutive P markers; the second one is Pr.
//   It then checks the 100-symbol frame and captures the time bits. At the
//   index-99 marker it precomputes time+1 s. The next rising edge, which is
//   the next frame's Pr, is the on-time instant: the outputs load and pps
//   rises there.
//
// Ports
//   sys_clk  in   system clock, rising edge
//   _rst     in   synchronous active-high reset
//   irig_in  in   IRIG-B DC-level code, asynchronous to sys_clk
//   sec      out  BCD seconds  [7:4] tens, [3:0] units
//   min      out  BCD minutes
//   hour     out  BCD hours
//   flag     out  locked, time outputs valid
//   pps      out  on-time pulse, PPS_CYCLES wide
//
// Parameters
//   TICK_CYCLES  sys_clk cycles per 0.1 ms tick (>= 2). Defaults to CLK_FREQ_MHZ*100.
//   PPS_CYCLES   pps high time in cycles. Defaults to PPS_WIDTH_MS*CLK_FREQ_MHZ*1000.
//
// Configuration macro
//   IRIG_BCD_RANGE_CHECK_EN  reject frames with out-of-range BCD digits
module irig_b_decoder #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int PPS_WIDTH_MS = 10,
  parameter int TICK_CYCLES  = CLK_FREQ_MHZ * 100,
  parameter int PPS_CYCLES   = PPS_WIDTH_MS * CLK_FREQ_MHZ * 1000
) (
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic       irig_in,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       flag,
  output logic       pps
);

  localparam int PW = $clog2(TICK_CYCLES + 1);
  localparam int CW = $clog2(PPS_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {HUNT, SYNC, FRAME, ARMED} state_e;
  typedef enum logic [1:0] {SYM_ZERO, SYM_ONE, SYM_P, SYM_INV} sym_e;

  state_e        r_state;
  logic [2:0]    r_sync;     // [1:0] synchronizer, [2] previous level
  logic [PW-1:0] r_pre;
  logic [7:0]    r_width;
  logic [7:0]    r_period;
  logic [6:0]    r_idx;      // index of the symbol classified at the next fall
  logic [19:0]   r_cap;      // {hr_t[1:0], hr_u, min_t[2:0], min_u, sec_t[2:0], sec_u}
  logic [23:0]   r_pend;
  logic [7:0]    r_sec, r_min, r_hour;
  logic          r_flag, r_pps;
  logic [CW-1:0] r_pps_cnt;

  function automatic sym_e classify(input logic [7:0] w);
    if (w >= 8'd15 && w <= 8'd35) return SYM_ZERO;
    if (w >= 8'd45 && w <= 8'd65) return SYM_ONE;
    if (w >= 8'd75 && w <= 8'd95) return SYM_P;
    return SYM_INV;
  endfunction

  // Maps a frame index to a bit position in r_cap, as {valid, pos}.
  function automatic logic [5:0] cap_slot(input logic [6:0] idx);
    case (idx)
      7'd1, 7'd2, 7'd3, 7'd4:     cap_slot = {1'b1, 5'(idx - 7'd1)};
      7'd6, 7'd7, 7'd8:           cap_slot = {1'b1, 5'(idx - 7'd2)};
      7'd10, 7'd11, 7'd12, 7'd13: cap_slot = {1'b1, 5'(idx - 7'd3)};
      7'd15, 7'd16, 7'd17:        cap_slot = {1'b1, 5'(idx - 7'd4)};
      7'd20, 7'd21, 7'd22, 7'd23: cap_slot = {1'b1, 5'(idx - 7'd6)};
      7'd25, 7'd26:               cap_slot = {1'b1, 5'(idx - 7'd7)};
      default:                    cap_slot = 6'd0;
    endcase
  endfunction

  // Adds one second. Raw digits are not checked. A units digit of 9 carries;
  // otherwise it wraps mod 16. Tens carry at 5. 23 rolls over to 00.
  function automatic logic [23:0] bump(input logic [19:0] c);
    logic [3:0] su, st, mu, mt, hu, ht;
    logic cy;
    su = c[3:0];   st = {1'b0, c[6:4]};
    mu = c[10:7];  mt = {1'b0, c[13:11]};
    hu = c[17:14]; ht = {2'b0, c[19:18]};
    cy = 1'b1;
    if (su == 4'd9) su = 4'd0; else begin su = su + 4'd1; cy = 1'b0; end
    if (cy) begin if (st == 4'd5) st = 4'd0; else begin st = st + 4'd1; cy = 1'b0; end end
    if (cy) begin if (mu == 4'd9) mu = 4'd0; else begin mu = mu + 4'd1; cy = 1'b0; end end
    if (cy) begin if (mt == 4'd5) mt = 4'd0; else begin mt = mt + 4'd1; cy = 1'b0; end end
    if (cy) begin
      if (ht == 4'd2 && hu == 4'd3) begin ht = 4'd0; hu = 4'd0; end
      else if (hu == 4'd9)          begin hu = 4'd0; ht = ht + 4'd1; end
      else                                hu = hu + 4'd1;
    end
    return {ht, hu, mt, mu, st, su};
  endfunction

  logic       w_rise, w_fall, w_tick, w_tmo, w_need_p;
  logic [5:0] w_slot;
  sym_e       w_sym;

  assign w_rise   = r_sync[1] & ~r_sync[2];
  assign w_fall   = ~r_sync[1] & r_sync[2];
  assign w_tick   = (r_pre == PRE_LAST);
  assign w_tmo    = (r_period > 8'd120) && !w_rise;  // an edge beats a timeout
  assign w_sym    = classify(r_width);
  assign w_slot   = cap_slot(r_idx);
  assign w_need_p = (r_idx == 7'd0) || (r_idx % 7'd10 == 7'd9);

`ifdef IRIG_BCD_RANGE_CHECK_EN
  logic w_bad;
  assign w_bad = (r_cap[3:0] > 4'd9)   || (r_cap[6:4] > 3'd5)   ||
                 (r_cap[10:7] > 4'd9)  || (r_cap[13:11] > 3'd5) ||
                 (r_cap[17:14] > 4'd9) || (r_cap[19:18] > 2'd2) ||
                 (r_cap[19:18] == 2'd2 && r_cap[17:14] > 4'd3);
`endif

  always_ff @(posedge sys_clk) begin
    if (_rst) begin
      r_state   <= HUNT;
      r_sync    <= '0;
      r_pre     <= '0;
      r_width   <= '0;
      r_period  <= '0;
      r_idx     <= '0;
      r_cap     <= '0;
      r_pend    <= '0;
      r_sec     <= '0;
      r_min     <= '0;
      r_hour    <= '0;
      r_flag    <= 1'b0;
      r_pps     <= 1'b0;
      r_pps_cnt <= '0;
    end else begin
      r_sync <= {r_sync[1:0], irig_in};

      // The rise cycle counts as the first prescaler cycle. This makes a
      // high time of N*TICK_CYCLES cycles measure exactly N ticks.
      if (w_rise)      r_pre <= PW'(1);
      else if (w_tick) r_pre <= '0;
      else             r_pre <= r_pre + PW'(1);

      if (w_rise) r_width <= '0;
      else if (w_tick && r_sync[1] && r_width != 8'hff) r_width <= r_width + 8'd1;

      if (w_rise) r_period <= '0;
      else if (w_tick && r_period != 8'hff) r_period <= r_period + 8'd1;

      // A pulse already started always runs to completion.
      if (r_pps) begin
        if (r_pps_cnt == '0) r_pps <= 1'b0;
        else                 r_pps_cnt <= r_pps_cnt - CW'(1);
      end

      if (w_rise && r_state == ARMED) begin
        {r_hour, r_min, r_sec} <= r_pend;
        r_flag    <= 1'b1;
        r_pps     <= 1'b1;
        r_pps_cnt <= CW'(PPS_CYCLES - 1);
        r_idx     <= '0;
        r_state   <= FRAME;
      end else if (w_tmo) begin
        r_state <= HUNT;
        r_flag  <= 1'b0;
      end else if (w_fall) begin
        if (w_sym == SYM_INV) begin
          r_state <= HUNT;
          r_flag  <= 1'b0;
        end else begin
          case (r_state)
            HUNT: if (w_sym == SYM_P) r_state <= SYNC;
            SYNC: begin
              if (w_sym == SYM_P) begin
                r_idx   <= 7'd1;  // this P was Pr (index 0)
                r_state <= FRAME;
              end else begin
                r_state <= HUNT;
              end
            end
            FRAME: begin
              if (w_need_p != (w_sym == SYM_P)) begin
                r_state <= HUNT;
                r_flag  <= 1'b0;
              end else if (r_idx == 7'd99) begin
`ifdef IRIG_BCD_RANGE_CHECK_EN
                if (w_bad) begin
                  r_state <= HUNT;
                  r_flag  <= 1'b0;
                end else begin
                  r_pend  <= bump(r_cap);
                  r_state <= ARMED;
                end
`else
                r_pend  <= bump(r_cap);
                r_state <= ARMED;
`endif
              end else begin
                if (w_slot[5]) r_cap[w_slot[4:0]] <= (w_sym == SYM_ONE);
                r_idx <= r_idx + 7'd1;
              end
            end
            default: ;  // ARMED waits for the Pr rising edge
          endcase
        end
      end
    end
  end

  assign sec  = r_sec;
  assign min  = r_min;
  assign hour = r_hour;
  assign flag = r_flag;
  assign pps  = r_pps;

endmodule

// File: tb/tb_irig_b_decoder.sv
// Directed bench for irig_b_decoder. It runs with a 2-cycle tick and a
// 300-cycle pps pulse, so each IRIG frame takes a few thousand cycles.
module tb_irig_b_decoder;
  logic       clk = 1'b0, rst = 1'b0, irig = 1'b0;
  logic [7:0] sec, min, hour;
  logic       flag, pps;

  always #5 clk = ~clk;

  irig_b_decoder #(.CLK_FREQ_MHZ(1), .PPS_WIDTH_MS(10), .TICK_CYCLES(2), .PPS_CYCLES(300)) dut (
    .sys_clk(clk), ._rst(rst), .irig_in(irig),
    .sec(sec), .min(min), .hour(hour), .flag(flag), .pps(pps));

  typedef struct {
    logic [7:0] h, m, s;     // encoded frame
    logic [7:0] eh, em, es;  // expected at the following Pr
  } vec_t;
  vec_t vecs[4];

  int   checks = 0, fails = 0;
  int   cyc = 0, last_rise = 0;
  int   pps_run = 0, pps_last = 0, pps_rises = 0;
  logic pps_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pps_q <= pps;
    if (pps) pps_run <= pps_run + 1;
    else if (pps_run != 0) begin pps_last <= pps_run; pps_run <= 0; end
    if (pps && !pps_q) pps_rises <= pps_rises + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_time(input string nm, input logic [7:0] h, m, s, input logic f);
    chk({nm, "_hour"}, hour, h);
    chk({nm, "_min"},  min,  m);
    chk({nm, "_sec"},  sec,  s);
    chk({nm, "_flag"}, flag, f);
  endtask

  // Returns the IRIG-B data bit at index i for the given BCD time, LSB first.
  function automatic bit enc_bit(input int i, input logic [7:0] h, m, s);
    if (i >= 1  && i <= 4)  return s[i-1];
    if (i >= 6  && i <= 8)  return s[i-2];
    if (i >= 10 && i <= 13) return m[i-10];
    if (i >= 15 && i <= 17) return m[i-11];
    if (i >= 20 && i <= 23) return h[i-20];
    if (i >= 25 && i <= 26) return h[i-21];
    return 1'b0;
  endfunction

  task automatic sym(input int w, input int lo);
    @(negedge clk); irig = 1'b1; last_rise = cyc;
    repeat (w*2) @(negedge clk);
    irig = 1'b0;
    repeat (lo*2) @(negedge clk);
  endtask

  // Sends indices 1..99. When stop_idx is reached, it sends stop_w instead
  // (nothing if stop_w is 0) and returns.
  task automatic send_data(input logic [7:0] h, m, s, input int w0, w1, wp,
                           input int stop_idx, input int stop_w);
    for (int i = 1; i <= 99; i++) begin
      if (i == stop_idx) begin
        if (stop_w > 0) sym(stop_w, 3);
        break;
      end
      sym((i % 10 == 9) ? wp : (enc_bit(i, h, m, s) ? w1 : w0), 3);
    end
  endtask

  // Raises the Pr edge. Checks pps 2 and 3 cycles later.
  task automatic pr_rise(input string nm, input logic exp_pps);
    @(negedge clk); irig = 1'b1; last_rise = cyc;
    repeat (2) @(negedge clk);
    chk({nm, "_pps_lat2"}, pps, 1'b0);
    @(negedge clk);
    chk({nm, "_pps_lat3"}, pps, exp_pps);
  endtask

  task automatic pr_finish(input int w);
    repeat (w*2 - 3) @(negedge clk);
    irig = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h57};
    vecs[1] = '{8'h12, 8'h34, 8'h57, 8'h12, 8'h34, 8'h58};
    vecs[2] = '{8'h23, 8'h59, 8'h59, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'h09, 8'h59, 8'h59, 8'h10, 8'h00, 8'h00};

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_time("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("reset_pps", pps, 1'b0);
    rst = 1'b0;

    // lock, then back-to-back frames from the table
    sym(80, 3); sym(80, 3);
    for (int v = 0; v < 4; v++) begin
      send_data(vecs[v].h, vecs[v].m, vecs[v].s, 20, 50, 80, 0, 0);
      pr_rise($sformatf("vec%0d", v), 1'b1);
      check_time($sformatf("vec%0d", v), vecs[v].eh, vecs[v].em, vecs[v].es, 1'b1);
      pr_finish(80);
    end

    // 5 ms pulse where the index-19 P belongs
    send_data(8'h11, 8'h22, 8'h33, 20, 50, 80, 19, 50);
    repeat (8) @(negedge clk);
    chk("bad_p19_flag", flag, 1'b0);
    chk("pps_width", pps_last, 300);
    chk("pps_count", pps_rises, 4);
    pr_rise("hunt", 1'b0);
    check_time("hunt_hold", 8'h10, 8'h00, 8'h00, 1'b0);
    chk("hunt_pps_count", pps_rises, 4);
    pr_finish(80);

    // width boundaries 15/65/95 accepted; this P is Pr after the one above
    sym(95, 3);
    send_data(8'h01, 8'h02, 8'h03, 15, 65, 95, 0, 0);
    pr_rise("edges", 1'b1);
    check_time("edges", 8'h01, 8'h02, 8'h04, 1'b1);
    pr_finish(95);
    send_data(8'h00, 8'h00, 8'h00, 20, 50, 80, 9, 96);
    repeat (8) @(negedge clk);
    chk("w96_flag", flag, 1'b0);

    // 14 ticks at a data index is invalid
    sym(80, 3); sym(80, 3);
    send_data(8'h12, 8'h00, 8'h00, 20, 50, 80, 0, 0);
    pr_rise("relock1", 1'b1);
    check_time("relock1", 8'h12, 8'h00, 8'h01, 1'b1);
    pr_finish(80);
    send_data(8'h12, 8'h00, 8'h01, 20, 50, 80, 3, 14);
    repeat (8) @(negedge clk);
    chk("w14_flag", flag, 1'b0);

    // line held low mid-frame
    sym(80, 3); sym(80, 3);
    send_data(8'h12, 8'h00, 8'h10, 20, 50, 80, 0, 0);
    pr_rise("relock2", 1'b1);
    check_time("relock2", 8'h12, 8'h00, 8'h11, 1'b1);
    pr_finish(80);
    send_data(8'h12, 8'h00, 8'h11, 20, 50, 80, 6, 0);
    while (cyc < last_rise + 200) @(negedge clk);
    chk("tmo_before", flag, 1'b1);
    while (cyc < last_rise + 300) @(negedge clk);
    chk("tmo_after", flag, 1'b0);
    while (cyc < last_rise + 700) @(negedge clk);
    check_time("tmo_hold", 8'h12, 8'h00, 8'h11, 1'b0);

    // frame with sec tens = 6, then reset during the pulse
    sym(80, 3); sym(80, 3);
    send_data(8'h23, 8'h00, 8'h60, 20, 50, 80, 0, 0);
`ifdef IRIG_BCD_RANGE_CHECK_EN
    pr_rise("range", 1'b0);
    check_time("range", 8'h12, 8'h00, 8'h11, 1'b0);
`else
    pr_rise("raw", 1'b1);
    check_time("raw", 8'h23, 8'h00, 8'h61, 1'b1);
`endif
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_time("rst_mid", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("rst_mid_pps", pps, 1'b0);
    rst = 1'b0;
    irig = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
